// File: rtl/sh7034_ext_slave.sv
// sh7034_ext_slave: turns SH7034 external-bus cycles for one area into single requests on a synchronous memory port.
// It also asks the CPU for the bus through BREQ_N/BACK_N on behalf of an external agent.
module sh7034_ext_slave #(
   parameter int BUS16   = 1,
   parameter int ABITS   = 22,
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [23:0]      A,
   input  logic [15:0]      BD_I,
   output logic [15:0]      BD_O,
   input  logic             CS_N,
   input  logic             RD_N,
   input  logic             WRH_N,
   input  logic             WRL_N,
   output logic             WAIT_N,
   output logic             BREQ_N,
   input  logic             BACK_N,
   input  logic             EXT_REQ,
   output logic             EXT_GRANT,
   output logic [ABITS-1:0] MEM_ADDR,
   output logic [15:0]      MEM_WD,
   output logic [1:0]       MEM_BE,
   output logic             MEM_WE,
   output logic             MEM_REQ,
   input  logic             MEM_ACK,
   input  logic [15:0]      MEM_RD,
   output logic             ERR
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
   state_t state, state_nxt;
   logic stb, stb_q, start, tmo, abort, a0, back_s1, back_s2, breq_nxt, unused_a;
   logic [7:0] cnt;
   logic [ABITS-1:0] addr_w;
   logic [15:0] rd_lane;
   // Edge-detect the strobes: CS_N stays low across byte-split sequences.
   assign stb       = ~CS_N & (~RD_N | ~WRH_N | ~WRL_N);
   assign start     = stb & ~stb_q & ~EXT_GRANT;
   assign tmo       = (state == REQ) & ~MEM_ACK & (cnt + 8'd1 == 8'(TIMEOUT));
   assign EXT_GRANT = ~back_s2 & ~BREQ_N;
   assign addr_w    = (BUS16 != 0) ? A[ABITS:1] : A[ABITS-1:0];
   assign rd_lane   = (BUS16 != 0) ? MEM_RD : {8'h00, a0 ? MEM_RD[7:0] : MEM_RD[15:8]};
   assign unused_a  = ^A;
   always_comb begin
      state_nxt = state;
      breq_nxt  = ~EXT_REQ | ((state == IDLE || EXT_GRANT) ? 1'b0 : BREQ_N);
      case (state)
         IDLE:    state_nxt = start ? REQ : IDLE;
         REQ:     state_nxt = MEM_ACK ? ((abort | ~stb) ? IDLE : HOLD) : (tmo ? HOLD : REQ);
         HOLD:    state_nxt = stb ? HOLD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stb_q    <= 1'b0;
         back_s1  <= 1'b1;
         back_s2  <= 1'b1;
         BREQ_N   <= 1'b1;
         WAIT_N   <= 1'b1;
         BD_O     <= '0;
         MEM_REQ  <= 1'b0;
         MEM_WE   <= 1'b0;
         MEM_BE   <= '0;
         MEM_ADDR <= '0;
         MEM_WD   <= '0;
         ERR      <= 1'b0;
         cnt      <= '0;
         abort    <= 1'b0;
         a0       <= 1'b0;
      end else begin
         stb_q   <= stb;
         back_s1 <= BACK_N;
         back_s2 <= back_s1;
         BREQ_N  <= breq_nxt;
         ERR     <= tmo;
         // Requests cannot be cancelled; any ack, even a late one, retires the pending request.
         if (MEM_ACK) MEM_REQ <= 1'b0;
         if (state == IDLE && start) begin
            WAIT_N   <= 1'b0;
            MEM_REQ  <= 1'b1;
            MEM_WE   <= RD_N;
            MEM_ADDR <= addr_w;
            MEM_BE   <= (BUS16 != 0) ? (RD_N ? {~WRH_N, ~WRL_N} : 2'b11) : (A[0] ? 2'b01 : 2'b10);
            cnt      <= '0;
            abort    <= 1'b0;
            a0       <= A[0];
            if (RD_N) MEM_WD <= (BUS16 != 0) ? BD_I : {BD_I[7:0], BD_I[7:0]};
         end
         if (state == REQ) begin
            cnt <= cnt + 8'd1;
            if (~stb) abort <= 1'b1;
            if (~stb | MEM_ACK | tmo) WAIT_N <= 1'b1;
            if (MEM_ACK & ~abort & stb & ~MEM_WE) BD_O <= rd_lane;
            else if (tmo) BD_O <= 16'hFFFF;
         end
      end
   end
endmodule

// File: tb/tb_sh7034_ext_slave.sv
// tb_sh7034_ext_slave: drives a 16-bit and an 8-bit instance with the same CPU bus traffic
// and checks both against expectations computed from the bus rules.
module tb_sh7034_ext_slave;
   logic CLK = 0, RST_N = 0;
   logic [23:0] A = '0;
   logic [15:0] BD_I = '0, MEM_RD = '0;
   logic CS_N = 1, RD_N = 1, WRH_N = 1, WRL_N = 1, BACK_N = 1, EXT_REQ = 0, MEM_ACK = 0;
   logic [15:0] bdo16, bdo8, wd16, wd8;
   logic wait16, wait8, breq16, breq8, grant16, grant8, we16, we8, req16, req8, err16, err8;
   logic [1:0] be16, be8;
   logic [21:0] addr16, addr8;
   int vec = 0, bad = 0, nreq16 = 0, nreq8 = 0, exp_nreq = 0;
   logic mr16 = 0, mr8 = 0;
   logic [15:0] e_bdo16 = '0, e_bdo8 = '0;

   always #5 CLK = ~CLK;

   sh7034_ext_slave #(.BUS16(1), .ABITS(22), .TIMEOUT(8)) u16 (
      .CLK(CLK), .RST_N(RST_N), .A(A), .BD_I(BD_I), .BD_O(bdo16), .CS_N(CS_N), .RD_N(RD_N),
      .WRH_N(WRH_N), .WRL_N(WRL_N), .WAIT_N(wait16), .BREQ_N(breq16), .BACK_N(BACK_N),
      .EXT_REQ(EXT_REQ), .EXT_GRANT(grant16), .MEM_ADDR(addr16), .MEM_WD(wd16), .MEM_BE(be16),
      .MEM_WE(we16), .MEM_REQ(req16), .MEM_ACK(MEM_ACK), .MEM_RD(MEM_RD), .ERR(err16));

   sh7034_ext_slave #(.BUS16(0), .ABITS(22), .TIMEOUT(8)) u8 (
      .CLK(CLK), .RST_N(RST_N), .A(A), .BD_I(BD_I), .BD_O(bdo8), .CS_N(CS_N), .RD_N(RD_N),
      .WRH_N(WRH_N), .WRL_N(WRL_N), .WAIT_N(wait8), .BREQ_N(breq8), .BACK_N(BACK_N),
      .EXT_REQ(EXT_REQ), .EXT_GRANT(grant8), .MEM_ADDR(addr8), .MEM_WD(wd8), .MEM_BE(be8),
      .MEM_WE(we8), .MEM_REQ(req8), .MEM_ACK(MEM_ACK), .MEM_RD(MEM_RD), .ERR(err8));

   // Count rising edges of MEM_REQ to catch missed or duplicated accesses.
   always @(posedge CLK) begin
      if (req16 && !mr16) nreq16 <= nreq16 + 1;
      if (req8 && !mr8) nreq8 <= nreq8 + 1;
      mr16 <= req16;
      mr8  <= req8;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // One CPU access; lat = ack latency in cycles after MEM_REQ, 0 = no ack (timeout).
   task automatic access(input logic wr, input logic [23:0] addr, input logic [1:0] wl,
                         input logic [15:0] wd, input int lat, input logic [15:0] rd, input logic keep_cs);
      int lim;
      logic t;
      lim = (lat > 0) ? lat : 8;
      t = (lat == 0);
      A = addr; BD_I = wd; CS_N = 0; RD_N = wr; WRH_N = ~(wr & wl[1]); WRL_N = ~(wr & wl[0]);
      exp_nreq++;
      @(negedge CLK);
      vec++;
      if ({req16, req8, we16, we8, be16, be8} !== {2'b11, wr, wr, (wr ? wl : 2'b11), (addr[0] ? 2'b01 : 2'b10)}) begin
         bad++;
         $display("FAIL req_ctrl a=%h got req/we/be %b%b %b%b %b %b want 11 %b%b %b %b", addr,
                  req16, req8, we16, we8, be16, be8, wr, wr, (wr ? wl : 2'b11), (addr[0] ? 2'b01 : 2'b10));
      end
      vec++;
      if ({addr16, addr8} !== {addr[22:1], addr[21:0]}) begin
         bad++;
         $display("FAIL mem_addr a=%h got %h/%h want %h/%h", addr, addr16, addr8, addr[22:1], addr[21:0]);
      end
      if (wr) begin
         vec++;
         if ({wd16, wd8} !== {wd, wd[7:0], wd[7:0]}) begin
            bad++;
            $display("FAIL mem_wd got %h/%h want %h/%h", wd16, wd8, wd, {wd[7:0], wd[7:0]});
         end
      end
      for (int k = 1; k <= lim; k++) begin
         if (k > 1) @(negedge CLK);
         vec++;
         if ({wait16, wait8} !== 2'b00) begin
            bad++;
            $display("FAIL wait_low cycle %0d got %b%b want 00", k, wait16, wait8);
         end
         if (k == lat) begin MEM_ACK = 1; MEM_RD = rd; end
      end
      if (lat == 0) begin e_bdo16 = 16'hFFFF; e_bdo8 = 16'hFFFF; end
      else if (!wr) begin e_bdo16 = rd; e_bdo8 = {8'h00, addr[0] ? rd[7:0] : rd[15:8]}; end
      @(negedge CLK);
      MEM_ACK = 0;
      vec++;
      if ({wait16, wait8, err16, err8, req16, req8} !== {2'b11, t, t, t, t}) begin
         bad++;
         $display("FAIL completion got wait/err/req %b%b %b%b %b%b want 11 %b%b %b%b",
                  wait16, wait8, err16, err8, req16, req8, t, t, t, t);
      end
      for (int h = 0; h < 3; h++) begin
         vec++;
         if ({bdo16, bdo8} !== {e_bdo16, e_bdo8}) begin
            bad++;
            $display("FAIL bd_o hold %0d got %h/%h want %h/%h", h, bdo16, bdo8, e_bdo16, e_bdo8);
         end
         if (h < 2) begin
            @(negedge CLK);
            vec++;
            if ({wait16, wait8, err16, err8} !== 4'b1100) begin
               bad++;
               $display("FAIL hold_state got wait/err %b%b %b%b want 11 00", wait16, wait8, err16, err8);
            end
         end
      end
      if (lat == 0) begin
         MEM_ACK = 1;
         @(negedge CLK);
         MEM_ACK = 0;
         vec++;
         if ({req16, req8} !== 2'b00) begin
            bad++;
            $display("FAIL late_ack got req %b%b want 00", req16, req8);
         end
      end
      RD_N = 1; WRH_N = 1; WRL_N = 1; CS_N = ~keep_cs;
      @(negedge CLK);
      vec++;
      if (nreq16 !== exp_nreq || nreq8 !== exp_nreq) begin
         bad++;
         $display("FAIL req_count got %0d/%0d want %0d", nreq16, nreq8, exp_nreq);
      end
   endtask

   task automatic test_reset;
      @(negedge CLK);
      vec++;
      if ({wait16, breq16, grant16, req16, we16, be16, err16, addr16, wd16, bdo16} !== {4'b1100, 1'b0, 2'b00, 1'b0, 22'h0, 16'h0, 16'h0}) begin
         bad++;
         $display("FAIL reset16 got %b%b%b%b%b %b %b %h %h %h want 11000 00 0 0 0 0", wait16, breq16, grant16, req16, we16, be16, err16, addr16, wd16, bdo16);
      end
      vec++;
      if ({wait8, breq8, grant8, req8, we8, be8, err8, addr8, wd8, bdo8} !== {4'b1100, 1'b0, 2'b00, 1'b0, 22'h0, 16'h0, 16'h0}) begin
         bad++;
         $display("FAIL reset8 got %b%b%b%b%b %b %b %h %h %h want 11000 00 0 0 0 0", wait8, breq8, grant8, req8, we8, be8, err8, addr8, wd8, bdo8);
      end
      RST_N = 1;
      repeat (2) @(negedge CLK);
      vec++;
      if ({wait16, wait8, breq16, breq8, req16, req8, err16, err8} !== 8'b11110000) begin
         bad++;
         $display("FAIL post_reset got %b want 11110000", {wait16, wait8, breq16, breq8, req16, req8, err16, err8});
      end
   endtask

   task automatic test_read16;
      access(1'b0, 24'h000124, 2'b11, 16'h0000, 5, 16'hBEEF, 1'b0);
   endtask

   task automatic test_write_lane;
      access(1'b1, 24'h000356, 2'b01, 16'h12AB, 3, 16'h0000, 1'b0);
   endtask

   task automatic test_byte_split;
      for (int i = 0; i < 4; i++)
         access(1'b1, 24'(32'h100 + i), 2'b01, 16'($urandom), $urandom_range(1, 4), 16'h0, 1'b1);
      CS_N = 1;
      @(negedge CLK);
   endtask

   task automatic test_timeout;
      access(1'b0, 24'h000A51, 2'b11, 16'h0, 0, 16'h0, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++)
         access(1'($urandom), 24'($urandom), 2'($urandom_range(1, 3)), 16'($urandom),
                $urandom_range(0, 8), 16'($urandom), 1'($urandom));
   endtask

   task automatic test_abort;
      A = 24'h000346; CS_N = 0; RD_N = 0; exp_nreq++;
      repeat (2) @(negedge CLK);
      CS_N = 1; RD_N = 1;
      @(negedge CLK);
      vec++;
      if ({wait16, wait8, req16, req8} !== 4'b1111) begin
         bad++;
         $display("FAIL abort_wait got wait/req %b%b %b%b want 11 11", wait16, wait8, req16, req8);
      end
      MEM_ACK = 1; MEM_RD = 16'h5A5A;
      @(negedge CLK);
      MEM_ACK = 0;
      vec++;
      if ({req16, req8, bdo16, bdo8} !== {2'b00, e_bdo16, e_bdo8}) begin
         bad++;
         $display("FAIL abort_ack got req %b%b bd %h/%h want 00 %h/%h", req16, req8, bdo16, bdo8, e_bdo16, e_bdo8);
      end
      access(1'b0, 24'h000347, 2'b11, 16'h0, 2, 16'hC3A5, 1'b0);
   endtask

   task automatic test_arbitration;
      A = 24'h000500; CS_N = 0; RD_N = 0; exp_nreq++;
      @(negedge CLK);
      EXT_REQ = 1;
      @(negedge CLK);
      vec++;
      if ({breq16, breq8} !== 2'b11) begin bad++; $display("FAIL breq_in_req got %b%b want 11", breq16, breq8); end
      MEM_ACK = 1; MEM_RD = 16'h1357;
      @(negedge CLK);
      MEM_ACK = 0;
      e_bdo16 = 16'h1357; e_bdo8 = 16'h0013;
      vec++;
      if ({breq16, breq8, bdo16, bdo8} !== {2'b11, e_bdo16, e_bdo8}) begin
         bad++;
         $display("FAIL breq_in_hold got %b%b bd %h/%h want 11 %h/%h", breq16, breq8, bdo16, bdo8, e_bdo16, e_bdo8);
      end
      CS_N = 1; RD_N = 1;
      @(negedge CLK);
      vec++;
      if ({breq16, breq8} !== 2'b11) begin bad++; $display("FAIL breq_leaving got %b%b want 11", breq16, breq8); end
      @(negedge CLK);
      vec++;
      if ({breq16, breq8, grant16, grant8} !== 4'b0000) begin
         bad++;
         $display("FAIL breq_idle got breq/grant %b%b %b%b want 00 00", breq16, breq8, grant16, grant8);
      end
      BACK_N = 0;
      @(negedge CLK);
      vec++;
      if ({grant16, grant8} !== 2'b00) begin bad++; $display("FAIL grant_sync1 got %b%b want 00", grant16, grant8); end
      @(negedge CLK);
      vec++;
      if ({grant16, grant8} !== 2'b11) begin bad++; $display("FAIL grant_sync2 got %b%b want 11", grant16, grant8); end
      A = 24'h000600; CS_N = 0; RD_N = 0;
      repeat (2) begin
         @(negedge CLK);
         vec++;
         if ({req16, req8, wait16, wait8} !== 4'b0011) begin
            bad++;
            $display("FAIL strobe_in_grant got req/wait %b%b %b%b want 00 11", req16, req8, wait16, wait8);
         end
      end
      CS_N = 1; RD_N = 1;
      @(negedge CLK);
      EXT_REQ = 0;
      @(negedge CLK);
      vec++;
      if ({breq16, breq8, grant16, grant8, nreq16 == exp_nreq, nreq8 == exp_nreq} !== 6'b110011) begin
         bad++;
         $display("FAIL release_bus got breq/grant %b%b %b%b reqs %0d/%0d want 11 00 %0d", breq16, breq8, grant16, grant8, nreq16, nreq8, exp_nreq);
      end
      BACK_N = 1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_reset_mid;
      A = 24'h000700; CS_N = 0; RD_N = 0; exp_nreq++;
      repeat (2) @(negedge CLK);
      #2 RST_N = 0;
      #1;
      CS_N = 1; RD_N = 1; e_bdo16 = '0; e_bdo8 = '0;
      vec++;
      if ({wait16, breq16, grant16, req16, we16, be16, err16, addr16, wd16, bdo16} !== {4'b1100, 1'b0, 2'b00, 1'b0, 22'h0, 16'h0, 16'h0}) begin
         bad++;
         $display("FAIL async_reset16 got %b%b%b%b%b %b %b %h %h %h want 11000 00 0 0 0 0", wait16, breq16, grant16, req16, we16, be16, err16, addr16, wd16, bdo16);
      end
      vec++;
      if ({wait8, breq8, grant8, req8, we8, be8, err8, addr8, wd8, bdo8} !== {4'b1100, 1'b0, 2'b00, 1'b0, 22'h0, 16'h0, 16'h0}) begin
         bad++;
         $display("FAIL async_reset8 got %b%b%b%b%b %b %b %h %h %h want 11000 00 0 0 0 0", wait8, breq8, grant8, req8, we8, be8, err8, addr8, wd8, bdo8);
      end
      @(negedge CLK);
      RST_N = 1;
      @(negedge CLK);
      access(1'b0, 24'h000702, 2'b11, 16'h0, 4, 16'h9C61, 1'b0);
   endtask

   initial begin
      test_reset;
      test_read16;
      test_write_lane;
      test_byte_split;
      test_timeout;
      test_abort;
      test_arbitration;
      test_random;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/sh7034_ext_slave.md
Name: sh7034_ext_slave

Overview:
- External-bus responder for the SH7034 external memory interface: the far end of the CPU's CS_N/RD_N/WRH_N/WRL_N/WAIT_N/BREQ_N/BACK_N pins.
- Decodes CPU strobes for one chip-select area and converts each bus cycle into a single request on a synchronous memory port (BRAM/SDRAM controller).
- Drives read data and stretches the CPU cycle through WAIT_N until the memory acknowledges.
- Also acts as bus-request master on behalf of an external agent (DMA/debug) via BREQ_N/BACK_N.

Parameters:
- BUS16, 1, area data width: 1 = 16-bit (WRH_N/WRL_N byte lanes), 0 = 8-bit (DI[7:0] only, lane chosen by A[0]).
- ABITS, 22, number of A bits forwarded to MEM_ADDR (word/byte address per BUS16).
- TIMEOUT, 255, maximum CLK cycles to wait for MEM_ACK before forced completion; 8-bit counter.

Ports:
- CLK in 1: system clock.
- RST_N in 1: asynchronous active-low reset.
- A in 24: CPU address bus.
- BD_I in 16: CPU write data (CPU DO).
- BD_O out 16: read data to CPU (CPU DI).
- CS_N in 1: area chip select from CPU.
- RD_N in 1: CPU read strobe.
- WRH_N in 1: upper-lane write strobe.
- WRL_N in 1: lower-lane write strobe.
- WAIT_N out 1: wait request to CPU, active low.
- BREQ_N out 1: bus request to CPU.
- BACK_N in 1: bus acknowledge from CPU.
- EXT_REQ in 1: external agent wants the bus.
- EXT_GRANT out 1: agent owns the bus.
- MEM_ADDR out ABITS: memory address.
- MEM_WD out 16: memory write data.
- MEM_BE out 2: byte enables, [1] = upper.
- MEM_WE out 1: 1 = write.
- MEM_REQ out 1: request, held until ack.
- MEM_ACK in 1: single-cycle acknowledge.
- MEM_RD in 16: memory read data, valid with MEM_ACK.
- ERR out 1: one-cycle pulse on timeout.

Behaviour:
- Reset values: WAIT_N=1, BD_O=0, BREQ_N=1, EXT_GRANT=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WD=0, ERR=0, FSM=IDLE, timeout counter=0.
- Reset is asynchronous and aborts any access, including mid-operation.
- All logic is clocked every CLK; no CE inputs are used.
- STB = ~CS_N & (~RD_N | ~WRH_N | ~WRL_N), registered once to give STB_Q.
- START = STB & ~STB_Q. Edge detection on the strobes, not on CS_N, because CS_N stays low across the CPU's byte-split sequences while the strobes toggle per access.
- While EXT_GRANT=1, START is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE --START--> REQ, on the same edge:
  - WAIT_N<=0.
  - MEM_REQ<=1.
  - MEM_WE<=RD_N.
  - MEM_ADDR<=A[ABITS:1] if BUS16, else A[ABITS-1:0].
  - Counter cleared.
  - Write, BUS16=1: MEM_WD<=BD_I; MEM_BE<={~WRH_N,~WRL_N}.
  - Write, BUS16=0: MEM_WD<={BD_I[7:0],BD_I[7:0]}; MEM_BE<= A[0] ? 2'b01 : 2'b10.
  - Read: MEM_BE<=2'b11 (BUS16) or the A[0] lane (8-bit).
- The CPU must be programmed for at least 1 wait state in this area. WAIT_N is low within 1 CLK of strobe assertion, which is before the first TW sample.
- REQ: counter increments each CLK.
  - On MEM_ACK: MEM_REQ<=0; on read, BD_O<=MEM_RD (8-bit: byte at A[0], upper byte if A[0]=0, placed on BD_O[7:0]); WAIT_N<=1; go to HOLD.
  - On counter==TIMEOUT: MEM_REQ stays high; BD_O<=16'hFFFF; WAIT_N<=1; ERR pulse; go to HOLD. A late MEM_ACK is then absorbed in HOLD/IDLE and drops MEM_REQ.
- HOLD: BD_O held stable; when STB=0, go to IDLE. Zero-wait back-to-back accesses are therefore impossible; the next START requires STB to fall first.
- Strobe withdrawn while in REQ (CPU reset):
  - WAIT_N<=1 immediately.
  - MEM_REQ kept until MEM_ACK, because requests cannot be cancelled.
  - Read data discarded; return to IDLE after the ack.
  - A new START is not accepted until then.
- Simultaneous MEM_ACK and strobe release in REQ: the ack is taken, then the FSM goes directly to IDLE.
- Arbitration:
  - BREQ_N<=~EXT_REQ only while the FSM is IDLE or EXT_GRANT=1.
  - BACK_N is double-synchronised. EXT_GRANT = ~BACK_N_sync & ~BREQ_N.
  - EXT_REQ fall: BREQ_N<=1 and EXT_GRANT<=0 on the same edge.
  - EXT_REQ rising while an access is in REQ/HOLD: BREQ_N asserts only after return to IDLE.

Test Plan:
- BUS16=1 read at A=0x000124, MEM_ACK 5 cycles after MEM_REQ with MEM_RD=0xBEEF -> MEM_ADDR=0x92, MEM_WE=0, BE=11; WAIT_N low for the span from START to ack; BD_O=0xBEEF held until RD_N rises; FSM back in IDLE.
- BUS16=1 write with only WRL_N low, BD_I=0x12AB -> MEM_WE=1, MEM_BE=01, MEM_WD=0x12AB, exactly one MEM_REQ.
- BUS16=0 long write split by the CPU into 4 byte strobes, CS_N continuously low, A=0x100..0x103 -> four MEM_REQs with BE 10,01,10,01 and bytes in order; no missed or duplicated access.
- MEM_ACK never arrives, TIMEOUT=8 -> WAIT_N releases 8 cycles after START; BD_O=0xFFFF; ERR high for one cycle; a late ack then clears MEM_REQ.
- EXT_REQ raised mid-read -> BREQ_N stays high until the FSM returns to IDLE; after BACK_N low, EXT_GRANT=1 after 2 sync cycles; strobes ignored during grant; EXT_REQ low drops BREQ_N and EXT_GRANT together.
- RST_N asserted while in REQ -> all outputs return to reset values asynchronously; after release the next START is served normally.
